// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the fetch-side PC logic.
//   PC_WIDTH     : width of every program-counter quantity
//   pc_state_t   : sequencer states BOOT / RUN / HALT
//   jump_target  : builds the J/JAL destination from pc+4 and the index field
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int PC_WIDTH = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // J-format destination: keep the 256 MB region of the delay-slot address
  // and drop the word index in below it.
  function automatic logic [PC_WIDTH-1:0] jump_target(
    input logic [PC_WIDTH-1:0] pc_plus4,
    input logic [25:0]         index
  );
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
// Control/fetch bundle between the instruction-decode side and the PC
// sequencer.
//   stall_i, branch_taken_i, branch_offset_i[31:0], jump_i, jump_index_i[25:0],
//   jr_i, jr_target_i[31:0], halt_i        : control towards the sequencer
//   pc_o[31:0], pc_plus4_o[31:0], fetch_valid_o, halted_o : fetch status back
//   misalign_trap_o, epc_o[31:0]           : only with PC_MISALIGN_TRAP_EN
// Modports: master = decode/controller side, slave = pc_sequencer.
// Optional feature macro: PC_MISALIGN_TRAP_EN
// ---------------------------------------------------------------------------
interface pc_sequencer_if;

  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic        halt_i;

  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        halted_o;

`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign_trap_o;
  logic [31:0] epc_o;

  modport master (
    output stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jr_i, jr_target_i, halt_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, halted_o, misalign_trap_o, epc_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jr_i, jr_target_i, halt_i,
    output pc_o, pc_plus4_o, fetch_valid_o, halted_o, misalign_trap_o, epc_o
  );
`else
  modport master (
    output stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jr_i, jr_target_i, halt_i,
    input  pc_o, pc_plus4_o, fetch_valid_o, halted_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_offset_i, jump_i, jump_index_i,
           jr_i, jr_target_i, halt_i,
    output pc_o, pc_plus4_o, fetch_valid_o, halted_o
  );
`endif

endinterface

// File: rtl/pc_sequencer_adder.sv
// ---------------------------------------------------------------------------
// pc_sequencer_adder
// Plain 32-bit adder used for both pc+4 and the branch target.
//   a_i[31:0], b_i[31:0] : operands
//   sum_o[31:0]          : (a_i + b_i) mod 2^32, carry-out discarded
// ---------------------------------------------------------------------------
module pc_sequencer_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for the fetch stage. After reset it spends one
// cycle in BOOT, then fetches sequentially in RUN, following jr / jump /
// branch redirects (in that priority) one edge after they are sampled, and
// parks in HALT when halt is seen until the next reset.
//   clk            : rising-edge clock
//   reset          : synchronous active-high reset, beats every other input
//   bus (slave)    : control inputs and pc / pc_plus4 / fetch_valid / halted
// Parameters: RESET_VECTOR (pc after reset), EXC_VECTOR (trap destination).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a jr to a non-word-aligned
// target redirects to EXC_VECTOR, records the faulting pc in epc and pulses
// misalign_trap. Without it the low target bits are simply ignored.
// ---------------------------------------------------------------------------
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  pc_state_t           state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                fetch_valid_q;
  logic                halted_q;

  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] branch_offset_shifted;
  logic [PC_WIDTH-1:0] branch_target;

`ifdef PC_MISALIGN_TRAP_EN
  logic                trap_d;
  logic                misalign_trap_q;
  logic [PC_WIDTH-1:0] epc_q;
`endif

  // Bits that are architecturally dropped: the top two offset bits fall off
  // the <<2, and without the trap the jr low bits and EXC_VECTOR do nothing.
  logic unused_bits;
`ifdef PC_MISALIGN_TRAP_EN
  assign unused_bits = ^bus.branch_offset_i[31:30];
`else
  assign unused_bits = ^{bus.branch_offset_i[31:30], bus.jr_target_i[1:0],
                         EXC_VECTOR};
`endif

  assign branch_offset_shifted = {bus.branch_offset_i[29:0], 2'b00};

  pc_sequencer_adder u_pc_plus4 (
    .a_i   (pc_q),
    .b_i   (32'd4),
    .sum_o (pc_plus4)
  );

  // Branches are relative to the delay-slot address, hence pc_plus4 here.
  pc_sequencer_adder u_branch_target (
    .a_i   (pc_plus4),
    .b_i   (branch_offset_shifted),
    .sum_o (branch_target)
  );

  // Candidate next pc for an un-stalled, non-halting RUN cycle.
  always_comb begin
    pc_d = pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d = 1'b0;
`endif
    if (bus.jr_i) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (bus.jr_target_i[1:0] != 2'b00) begin
        pc_d   = EXC_VECTOR;
        trap_d = 1'b1;
      end else begin
        pc_d = bus.jr_target_i;
      end
`else
      pc_d = {bus.jr_target_i[31:2], 2'b00};
`endif
    end else if (bus.jump_i) begin
      pc_d = jump_target(pc_plus4, bus.jump_index_i);
    end else if (bus.branch_taken_i) begin
      pc_d = branch_target;
    end
  end

  // Sequencer FSM with registered status outputs. BOOT and HALT ignore all
  // control inputs; in RUN a stall freezes everything for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      fetch_valid_q   <= 1'b0;
      halted_q        <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_trap_q <= 1'b0;
      epc_q           <= '0;
`endif
    end else begin
`ifdef PC_MISALIGN_TRAP_EN
      // The trap flag is a single-cycle event, so it drops by default.
      misalign_trap_q <= 1'b0;
`endif
      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
        end
        RUN: begin
          if (!bus.stall_i) begin
            if (bus.halt_i) begin
              state_q       <= HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
            end else begin
              pc_q <= pc_d;
`ifdef PC_MISALIGN_TRAP_EN
              if (trap_d) begin
                misalign_trap_q <= 1'b1;
                epc_q           <= pc_q;
              end
`endif
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_plus4;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.halted_o      = halted_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_trap_o = misalign_trap_q;
  assign bus.epc_o           = epc_q;
`endif

endmodule
